// File: rtl/seven_seg_scanner_pkg.sv
// Shared display constants: digit count, blank patterns and the active-low
// hex glyph table in {g,f,e,d,c,b,a} order.
package seven_seg_scanner_pkg;

  localparam int DIGIT_COUNT = 8;
  localparam int IDX_W       = 3;

  localparam logic [DIGIT_COUNT-1:0] AN_BLANK  = 8'hFF;
  localparam logic [6:0]             CAT_BLANK = 7'h7F;

  // Entry n is the glyph for hex digit n (entry 0 sits in the low bits).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef logic [DIGIT_COUNT-1:0][3:0] digits_t;

endpackage

// File: rtl/seven_seg_scanner_hex_to_seg7.sv
// Combinational nibble to active-low seven-segment glyph.
module hex_to_seg7
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seven_seg_scanner.sv
// Eight-digit multiplexed hex display with a write-pending buffer that only
// commits at the frame boundary, so a frame never mixes two values.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        WE,
  input  logic [31:0] WD,
  input  logic        Blank,
  output logic        Pending,
  output logic [7:0]  SevenSegAn,
  output logic [6:0]  SevenSegCat
);

  localparam logic [15:0] PRESC_LAST = 16'(REFRESH_DIV - 1);

  logic [15:0]            presc;
  logic [IDX_W-1:0]       idx;
  digits_t                disp, pend;
  logic [31:0]            disp_flat;
  logic [DIGIT_COUNT-1:0] upper_nz;
  logic [6:0]             seg;
  logic                   tc, frame_end, blank_dig;

  assign tc        = (presc == PRESC_LAST);
  assign frame_end = tc && (idx == IDX_W'(DIGIT_COUNT - 1));
  assign disp_flat = disp;

  // upper_nz[i]: some nibble at position i or above is non-zero.
  for (genvar i = 0; i < DIGIT_COUNT; i++) begin : g_nz
    assign upper_nz[i] = |disp_flat[31:4*i];
  end

  assign blank_dig = Blank && (idx != '0) && !upper_nz[idx];

  hex_to_seg7 u_dec (
    .hex (disp[idx]),
    .seg (seg)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (tc) begin
      presc <= '0;
      idx   <= idx + IDX_W'(1);
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // A write on the boundary cycle still lands in pending, after the old
  // pending value has been committed.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      disp    <= '0;
      pend    <= '0;
      Pending <= 1'b0;
    end else begin
      if (frame_end && Pending) disp <= pend;
      if (WE) begin
        pend    <= WD;
        Pending <= 1'b1;
      end else if (frame_end) begin
        Pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      SevenSegAn  <= AN_BLANK;
      SevenSegCat <= CAT_BLANK;
    end else if (blank_dig) begin
      SevenSegAn  <= AN_BLANK;
      SevenSegCat <= CAT_BLANK;
    end else begin
      SevenSegAn  <= ~(8'h01 << idx);
      SevenSegCat <= seg;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench: a cycle-count reference model pushes the expected outputs
// every edge; a negedge monitor pops and compares against the DUT.
module tb_seven_seg_scanner;

  localparam int RD    = 3;
  localparam int FRAME = RD * 8;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] WD = '0;
  logic        Blank = 1'b0;
  logic        Pending;
  logic [7:0]  SevenSegAn;
  logic [6:0]  SevenSegCat;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] cat;
    logic       pend;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cnt = 0;

  logic [31:0] m_disp = '0;
  logic [31:0] m_pend = '0;
  logic        m_pv = 1'b0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seven_seg_scanner #(.REFRESH_DIV(RD)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .WE          (WE),
    .WD          (WD),
    .Blank       (Blank),
    .Pending     (Pending),
    .SevenSegAn  (SevenSegAn),
    .SevenSegCat (SevenSegCat)
  );

  always #5 CLK = ~CLK;

  // Reference model: slot and frame position derived from edges since reset.
  initial begin : model
    exp_t       e;
    int         slot;
    bit         bnd, blk;
    logic [3:0] nib;
    forever begin
      @(posedge CLK);
      if (!Reset) begin
        cnt = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
        e = '{an: 8'hFF, cat: 7'h7F, pend: 1'b0};
      end else begin
        slot = (cnt / RD) % 8;
        bnd  = (cnt % FRAME) == FRAME - 1;
        nib  = 4'(m_disp >> (4 * slot));
        blk  = Blank && (slot > 0) && ((m_disp >> (4 * slot)) == 0);
        e.an  = blk ? 8'hFF : ~(8'h01 << slot);
        e.cat = blk ? 7'h7F : glyph[nib];
        if (bnd && m_pv) m_disp = m_pend;
        if (WE) begin m_pend = WD; m_pv = 1'b1; end
        else if (bnd) m_pv = 1'b0;
        e.pend = m_pv;
        cnt++;
      end
      q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (SevenSegAn !== e.an || SevenSegCat !== e.cat || Pending !== e.pend) begin
          failures++;
          $display("FAIL scan t=%0t an=%h exp=%h cat=%h exp=%h pend=%b exp=%b",
                   $time, SevenSegAn, e.an, SevenSegCat, e.cat, Pending, e.pend);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while ((cnt % FRAME) != p && n < 2 * FRAME) begin
      @(negedge CLK);
      n++;
    end
    if ((cnt % FRAME) != p) begin
      checks++;
      failures++;
      $display("FAIL wait_pos timeout got=%0d exp=%0d", cnt % FRAME, p);
    end
  endtask

  task automatic wr(input logic [31:0] d);
    WE = 1'b1;
    WD = d;
    @(negedge CLK);
    WE = 1'b0;
  endtask

  initial begin : stim
    repeat (2) @(negedge CLK);
    chk("rst_an", 32'(SevenSegAn), 32'hFF);
    chk("rst_cat", 32'(SevenSegCat), 32'h7F);
    chk("rst_pend", 32'(Pending), 32'h0);
    #2 Reset = 1'b1;
    @(negedge CLK);

    // idle scan
    repeat (2 * FRAME) @(negedge CLK);

    // write at index 3, commit on wrap
    wait_pos(3 * RD);
    wr(32'h12345678);
    chk("pend_after_we", 32'(Pending), 32'h1);
    repeat (2 * FRAME) @(negedge CLK);

    // leading-zero blanking
    Blank = 1'b1;
    wr(32'h000000A5);
    repeat (2 * FRAME) @(negedge CLK);
    Blank = 1'b0;

    // write mid-frame, second write on the wrap cycle
    wait_pos(10);
    wr(32'h11111111);
    wait_pos(FRAME - 1);
    wr(32'h22222222);
    repeat (3 * FRAME) @(negedge CLK);

    // three writes in one frame
    wait_pos(2);
    wr(32'hAAAA0001);
    wait_pos(8);
    wr(32'hBBBB0002);
    wait_pos(15);
    wr(32'h0C0D0E0F);
    repeat (2 * FRAME) @(negedge CLK);

    // async reset mid-frame with a write pending
    wait_pos(5);
    wr(32'hDEADBEEF);
    #2 Reset = 1'b0;
    #1;
    chk("async_an", 32'(SevenSegAn), 32'hFF);
    chk("async_cat", 32'(SevenSegCat), 32'h7F);
    chk("async_pend", 32'(Pending), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    #2 Reset = 1'b1;
    @(negedge CLK);
    repeat (2 * FRAME) @(negedge CLK);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      WE = ($urandom % 6) == 0;
      WD = $urandom >> (4 * $urandom_range(0, 8));
      if (($urandom % 40) == 0) Blank = ~Blank;
      @(negedge CLK);
    end
    WE = 1'b0;
    repeat (3) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 4, giving the clock cycles each digit stays lit (legal range 2..65535).
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports named as the codebase names them.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-low; 0 clears all state.
REQ-005 SHALL have port WE, input, 1 bit: write strobe from the processor I/O decode; sampled every cycle.
REQ-006 SHALL have port WD, input, 32 bits: eight hex nibbles to display; nibble i drives digit i, with digit 0 rightmost.
REQ-007 SHALL have port Blank, input, 1 bit: enables leading-zero blanking; sampled live.
REQ-008 SHALL have port Pending, output, 1 bit: a written value is waiting for the frame boundary.
REQ-009 SHALL have port SevenSegAn, output, 8 bits: digit anodes, active-low, one-hot-low or all-high.
REQ-010 SHALL have port SevenSegCat, output, 7 bits: segment cathodes, active-low, in bit order {g,f,e,d,c,b,a}.

Function
REQ-011 SHALL run a prescale counter 0..REFRESH_DIV-1; at terminal count it wraps to 0 and the 3-bit digit index increments, with 7 wrapping to 0.
REQ-012 SHALL register SevenSegAn and SevenSegCat from the current index and display register, with one cycle of latency and no combinational path from WE, WD or Blank.
REQ-013 SHALL drive SevenSegAn bit index low and all other bits high, except when the digit is blanked (REQ-016), when all bits are high.
REQ-014 SHALL decode SevenSegCat as hex 0..F; 0=0x40, 1=0x79, 5=0x12, 8=0x00, A=0x08, F=0x0E; all other codes follow the standard hex glyph set.
REQ-015 SHALL on WE=1 load WD into the pending register and set Pending; with multiple writes in one frame, the last write wins.
REQ-016 SHALL blank digit i (i>=1) when Blank=1 and display nibbles i..7 are all zero; digit 0 is never blanked, so the value 0 shows "0".
REQ-017 SHALL at a frame boundary (index 7->0 transition) with Pending=1 copy pending into the display register and clear Pending in the same cycle.
REQ-018 SHALL on a simultaneous WE and frame boundary commit the old pending value to display, load WD into pending, and keep Pending=1.
REQ-019 SHALL never change the display register mid-frame (tear-free).

Reset
REQ-020 SHALL while Reset=0 force: prescale=0, index=0, display=0, pending=0, Pending=0, SevenSegAn=0xFF, SevenSegCat=0x7F.
REQ-021 SHALL apply reset asynchronously, including mid-frame or mid-write; an in-flight pending value is discarded.
REQ-022 SHALL after reset release show digit 0 (SevenSegAn=0xFE, SevenSegCat=0x40) from the first rising edge.

Structure
REQ-023 SHALL take from a shared display package: the 16-entry segment code table constants, DIGIT_COUNT=8, and the blank anode pattern 0xFF / blank cathode pattern 0x7F.
REQ-024 SHALL place the combinational nibble-to-segment decode in one sub-module, hex_to_seg7 (4-bit in, 7-bit out), reused by the processor top level.

Verification (REFRESH_DIV=3, frame = 24 cycles)
REQ-025 SHALL cover: reset, then no writes -> SevenSegAn steps 0xFE,0xFD,...,0x7F, each held 3 cycles, then repeats; SevenSegCat=0x40 throughout.
REQ-026 SHALL cover: WE with WD=0x12345678 at index 3 -> Pending=1 and the display unchanged until the 7->0 wrap; then digit 0 shows 0x00, digit 7 shows 0x79, and Pending=0.
REQ-027 SHALL cover: Blank=1 with WD=0x000000A5 committed -> SevenSegAn=0xFF during slots 2..7; digit 0 shows 0x12 and digit 1 shows 0x08.
REQ-028 SHALL cover: WE with 0x11111111 mid-frame, then WE with 0x22222222 on the wrap cycle -> the next frame shows all 0x79 with Pending=1, and the following frame shows 2s (0x24) with Pending=0.
REQ-029 SHALL cover: Reset=0 asserted mid-frame with Pending=1 -> SevenSegAn=0xFF and SevenSegCat=0x7F immediately and Pending=0; after release, the display shows 0.
REQ-030 SHALL cover: three writes within one frame -> only the third value appears after the boundary.
